// File: rtl/rv32i_decoding_stage.sv
// rv32i_decoding_stage: RV32I decode, 32x32 register file with write-through bypass, ID/EX register
module rv32i_decoding_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL_DECODING_STAGE,
  input  logic        CLEAR_DECODING_STAGE,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] RD_DATA_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  input  logic [31:0] INSTRUCTION,
  input  logic [31:0] PC_IN,
  output logic [31:0] PC_OUT,
  output logic [4:0]  RS1_ADDRESS,
  output logic [4:0]  RS2_ADDRESS,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] RS1_DATA,
  output logic [31:0] RS2_DATA,
  output logic [31:0] IMM_OUTPUT,
  output logic [4:0]  SHIFT_AMOUNT,
  output logic [4:0]  ALU_INSTRUCTION,
  output logic        ALU_INPUT_1_SELECT,
  output logic        ALU_INPUT_2_SELECT,
  output logic [2:0]  DATA_CACHE_READ,
  output logic [1:0]  DATA_CACHE_WRITE,
  output logic [31:0] DATA_CACHE_WRITE_DATA,
  output logic        WRITE_BACK_MUX_SELECT,
  output logic        RD_WRITE_ENABLE_OUT
);
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [4:0]  rd_a;
    logic [31:0] rs1_d;
    logic [31:0] rs2_d;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  alu;
    logic        sel1;
    logic        sel2;
    logic [2:0]  rd_op;
    logic [1:0]  wr_op;
    logic        wb;
    logic        we;
  } idex_t;
  idex_t d, q;
  logic [31:0] regs [32];
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, alu_r, alu_i, alu_b;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ok;
  assign op  = INSTRUCTION[6:0];
  assign f3  = INSTRUCTION[14:12];
  assign f7  = INSTRUCTION[31:25];
  assign rs1 = INSTRUCTION[19:15];
  assign rs2 = INSTRUCTION[24:20];
  assign imm_i = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
  assign imm_s = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
  assign imm_b = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7], INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
  assign imm_u = {INSTRUCTION[31:12], 12'd0};
  assign imm_j = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12], INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
  // a write landing this cycle is forwarded so the operand is never stale
  assign rs1_v = rs1 == 5'd0 ? 32'd0 : RD_WRITE_ENABLE_IN && RD_ADDRESS_IN == rs1 ? RD_DATA_IN : regs[rs1];
  assign rs2_v = rs2 == 5'd0 ? 32'd0 : RD_WRITE_ENABLE_IN && RD_ADDRESS_IN == rs2 ? RD_DATA_IN : regs[rs2];
  assign alu_r = f3 == 3'd0 ? (f7[5] ? 5'd2 : 5'd1) :
                 f3 == 3'd1 ? 5'd3 :
                 f3 == 3'd2 ? 5'd4 :
                 f3 == 3'd3 ? 5'd5 :
                 f3 == 3'd4 ? 5'd6 :
                 f3 == 3'd5 ? (f7[5] ? 5'd8 : 5'd7) :
                 f3 == 3'd6 ? 5'd9 : 5'd10;
  assign alu_i = f3 == 3'd0 ? 5'd1 : f3 == 3'd1 ? 5'd11 : f3 == 3'd5 ? (f7[5] ? 5'd13 : 5'd12) : alu_r;
  assign alu_b = f3 == 3'd0 ? 5'd15 : f3 == 3'd1 ? 5'd16 : 5'd13 + {2'd0, f3};
  always_comb begin
    d = '0;
    ok = 1'b0;
    d.pc = PC_IN;
    d.rs1_a = rs1;
    d.rs2_a = rs2;
    d.rd_a = INSTRUCTION[11:7];
    d.rs1_d = rs1_v;
    d.rs2_d = rs2_v;
    d.shamt = rs2;
    case (op)
      7'b0110011: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        d.alu = alu_r;
        d.we = 1'b1;
      end
      7'b0010011: begin
        ok = f3 == 3'd1 ? f7 == 7'h00 : f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20;
        d.alu = alu_i;
        d.imm = imm_i;
        d.sel2 = 1'b1;
        d.we = 1'b1;
      end
      7'b0000011: begin
        ok = f3 != 3'd3 && f3 < 3'd6;
        d.alu = 5'd1;
        d.imm = imm_i;
        d.sel2 = 1'b1;
        d.rd_op = f3[2] ? f3 : f3 + 3'd1;
        d.wb = 1'b1;
        d.we = 1'b1;
      end
      7'b0100011: begin
        ok = f3 < 3'd3;
        d.alu = 5'd1;
        d.imm = imm_s;
        d.sel2 = 1'b1;
        d.wr_op = f3[1:0] + 2'd1;
      end
      7'b1100011: begin
        ok = f3[2:1] != 2'b01;
        d.alu = alu_b;
        d.imm = imm_b;
      end
      7'b0110111: begin
        ok = 1'b1;
        d.alu = 5'd14;
        d.imm = imm_u;
        d.we = 1'b1;
      end
      7'b0010111: begin
        ok = 1'b1;
        d.alu = 5'd1;
        d.imm = imm_u;
        d.sel1 = 1'b1;
        d.sel2 = 1'b1;
        d.we = 1'b1;
      end
      7'b1101111: begin
        ok = 1'b1;
        d.alu = 5'd21;
        d.imm = imm_j;
        d.sel1 = 1'b1;
        d.we = 1'b1;
      end
      7'b1100111: begin
        ok = f3 == 3'd0;
        d.alu = 5'd22;
        d.imm = imm_i;
        d.we = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) d = '0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (RD_WRITE_ENABLE_IN && RD_ADDRESS_IN != 5'd0) regs[RD_ADDRESS_IN] <= RD_DATA_IN;
  always_ff @(posedge CLK or posedge RST)
    if (RST) q <= '0;
    else if (CLEAR_DECODING_STAGE) q <= '0;
    else if (!STALL_DECODING_STAGE) q <= d;
  assign PC_OUT = q.pc;
  assign RS1_ADDRESS = q.rs1_a;
  assign RS2_ADDRESS = q.rs2_a;
  assign RD_ADDRESS_OUT = q.rd_a;
  assign RS1_DATA = q.rs1_d;
  assign RS2_DATA = q.rs2_d;
  assign IMM_OUTPUT = q.imm;
  assign SHIFT_AMOUNT = q.shamt;
  assign ALU_INSTRUCTION = q.alu;
  assign ALU_INPUT_1_SELECT = q.sel1;
  assign ALU_INPUT_2_SELECT = q.sel2;
  assign DATA_CACHE_READ = q.rd_op;
  assign DATA_CACHE_WRITE = q.wr_op;
  assign DATA_CACHE_WRITE_DATA = q.rs2_d;
  assign WRITE_BACK_MUX_SELECT = q.wb;
  assign RD_WRITE_ENABLE_OUT = q.we;
endmodule

// File: tb/tb_rv32i_decoding_stage.sv
// tb_rv32i_decoding_stage: directed plan checks plus randomized instructions against a mnemonic-table model
module tb_rv32i_decoding_stage;
  logic        CLK = 1'b0, RST = 1'b0;
  logic        STALL_DECODING_STAGE = 1'b0, CLEAR_DECODING_STAGE = 1'b0, RD_WRITE_ENABLE_IN = 1'b0;
  logic [4:0]  RD_ADDRESS_IN = '0;
  logic [31:0] RD_DATA_IN = '0, INSTRUCTION = '0, PC_IN = '0;
  logic [31:0] PC_OUT, RS1_DATA, RS2_DATA, IMM_OUTPUT, DATA_CACHE_WRITE_DATA;
  logic [4:0]  RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_OUT, SHIFT_AMOUNT, ALU_INSTRUCTION;
  logic        ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT, WRITE_BACK_MUX_SELECT, RD_WRITE_ENABLE_OUT;
  logic [2:0]  DATA_CACHE_READ;
  logic [1:0]  DATA_CACHE_WRITE;
  rv32i_decoding_stage dut (
    .CLK(CLK), .RST(RST),
    .STALL_DECODING_STAGE(STALL_DECODING_STAGE), .CLEAR_DECODING_STAGE(CLEAR_DECODING_STAGE),
    .RD_ADDRESS_IN(RD_ADDRESS_IN), .RD_DATA_IN(RD_DATA_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
    .INSTRUCTION(INSTRUCTION), .PC_IN(PC_IN), .PC_OUT(PC_OUT),
    .RS1_ADDRESS(RS1_ADDRESS), .RS2_ADDRESS(RS2_ADDRESS), .RD_ADDRESS_OUT(RD_ADDRESS_OUT),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .IMM_OUTPUT(IMM_OUTPUT), .SHIFT_AMOUNT(SHIFT_AMOUNT),
    .ALU_INSTRUCTION(ALU_INSTRUCTION), .ALU_INPUT_1_SELECT(ALU_INPUT_1_SELECT),
    .ALU_INPUT_2_SELECT(ALU_INPUT_2_SELECT), .DATA_CACHE_READ(DATA_CACHE_READ),
    .DATA_CACHE_WRITE(DATA_CACHE_WRITE), .DATA_CACHE_WRITE_DATA(DATA_CACHE_WRITE_DATA),
    .WRITE_BACK_MUX_SELECT(WRITE_BACK_MUX_SELECT), .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         fmt;
    logic [4:0] alu;
    logic       s1, s2;
    logic [2:0] rd;
    logic [1:0] wr;
    logic       wb, we;
  } ent_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  sh, alu;
    logic        s1, s2;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic        wb, we;
  } exp_t;
  ent_t        tbl[$];
  exp_t        ex, nx;
  logic        ex_pc, nx_pc;
  logic [31:0] mregs [32];
  int          passed = 0, total = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask
  // fmt: 0 R, 1 I, 2 shift-imm, 3 S, 4 B, 5 U, 6 J
  task automatic add_ent(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input int fmt,
                         input logic [4:0] alu, input logic s1, s2, input logic [2:0] rd, input logic [1:0] wr,
                         input logic wb, we);
    ent_t e;
    e = '{op, f3, f7, fmt, alu, s1, s2, rd, wr, wb, we};
    tbl.push_back(e);
  endtask
  function automatic logic [31:0] opnd(input logic [4:0] a);
    return a == 5'd0 ? 32'd0 : (RD_WRITE_ENABLE_IN && RD_ADDRESS_IN == a) ? RD_DATA_IN : mregs[a];
  endfunction
  task automatic gen_valid(input int k);
    ent_t e;
    logic [4:0] r1, r2, rdd;
    logic [31:0] v, ins;
    e = tbl[k];
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    rdd = 5'($urandom);
    v = '0;
    ins = '0;
    case (e.fmt)
      0: ins = {e.f7, r2, r1, e.f3, rdd, e.op};
      1: begin
        v = 32'($urandom_range(0, 4095)) - 32'd2048;
        ins = {v[11:0], r1, e.f3, rdd, e.op};
      end
      2: begin
        v = 32'(e.f7) * 32 + 32'(r2);
        ins = {e.f7, r2, r1, e.f3, rdd, e.op};
      end
      3: begin
        v = 32'($urandom_range(0, 4095)) - 32'd2048;
        ins = {v[11:5], r2, r1, e.f3, v[4:0], e.op};
      end
      4: begin
        v = 32'($urandom_range(0, 4095)) * 2 - 32'd4096;
        ins = {v[12], v[10:5], r2, r1, e.f3, v[4:1], v[11], e.op};
      end
      5: begin
        v = 32'($urandom_range(0, 1048575)) * 4096;
        ins = {v[31:12], rdd, e.op};
      end
      default: begin
        v = 32'($urandom_range(0, 1048575)) * 2 - 32'd1048576;
        ins = {v[20], v[10:1], v[11], v[19:12], rdd, e.op};
      end
    endcase
    INSTRUCTION = ins;
    nx = '{PC_IN, ins[19:15], ins[24:20], ins[11:7], opnd(ins[19:15]), opnd(ins[24:20]), v, ins[24:20],
           e.alu, e.s1, e.s2, e.rd, e.wr, e.wb, e.we};
    nx_pc = 1'b1;
  endtask
  task automatic gen_illegal();
    logic [31:0] ins;
    logic [6:0] bad_ops [5];
    bad_ops = '{7'b0001111, 7'b1110011, 7'b0000000, 7'b1111111, 7'b0101111};
    ins = $urandom;
    case ($urandom_range(0, 8))
      0: ins[6:0] = bad_ops[$urandom_range(0, 4)];
      1: begin ins[6:0] = 7'b0110011; ins[31:25] = 7'h01; end
      2: begin ins[6:0] = 7'b0000011; ins[14:12] = 3'($urandom_range(0, 2)) == 3'd0 ? 3'd3 : 3'(5 + $urandom_range(1, 2)); end
      3: begin ins[6:0] = 7'b0100011; ins[14:12] = 3'($urandom_range(3, 7)); end
      4: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'($urandom_range(2, 3)); end
      5: begin ins[6:0] = 7'b0010011; ins[14:12] = 3'd1; ins[31:25] = 7'h20; end
      6: begin ins[6:0] = 7'b0010011; ins[14:12] = 3'd5; ins[31:25] = 7'h10; end
      7: begin ins[6:0] = 7'b1100111; ins[14:12] = 3'($urandom_range(1, 7)); end
      default: begin ins[6:0] = 7'b0110011; ins[31:25] = 7'h20; ins[14:12] = 3'($urandom_range(0, 1)) == 3'd0 ? 3'd1 : 3'(6 + $urandom_range(0, 1)); end
    endcase
    INSTRUCTION = ins;
    nx = '0;
    nx_pc = 1'b0;
  endtask
  task automatic check_out();
    if (ex_pc) chk("pc", PC_OUT, ex.pc);
    chk("rs1_addr", 32'(RS1_ADDRESS), 32'(ex.rs1a));
    chk("rs2_addr", 32'(RS2_ADDRESS), 32'(ex.rs2a));
    chk("rd_addr", 32'(RD_ADDRESS_OUT), 32'(ex.rda));
    chk("rs1_data", RS1_DATA, ex.rs1d);
    chk("rs2_data", RS2_DATA, ex.rs2d);
    chk("imm", IMM_OUTPUT, ex.imm);
    chk("shamt", 32'(SHIFT_AMOUNT), 32'(ex.sh));
    chk("alu", 32'(ALU_INSTRUCTION), 32'(ex.alu));
    chk("sel1", 32'(ALU_INPUT_1_SELECT), 32'(ex.s1));
    chk("sel2", 32'(ALU_INPUT_2_SELECT), 32'(ex.s2));
    chk("dc_read", 32'(DATA_CACHE_READ), 32'(ex.rd));
    chk("dc_write", 32'(DATA_CACHE_WRITE), 32'(ex.wr));
    chk("dc_wdata", DATA_CACHE_WRITE_DATA, ex.rs2d);
    chk("wb_sel", 32'(WRITE_BACK_MUX_SELECT), 32'(ex.wb));
    chk("rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'(ex.we));
  endtask
  task automatic step(input logic [31:0] ins, pc, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic st, cl);
    INSTRUCTION = ins;
    PC_IN = pc;
    RD_WRITE_ENABLE_IN = we;
    RD_ADDRESS_IN = wa;
    RD_DATA_IN = wd;
    STALL_DECODING_STAGE = st;
    CLEAR_DECODING_STAGE = cl;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    add_ent(7'b0110011, 3'd0, 7'h00, 0, 5'd1, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd0, 7'h20, 0, 5'd2, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd1, 7'h00, 0, 5'd3, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd2, 7'h00, 0, 5'd4, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd3, 7'h00, 0, 5'd5, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd4, 7'h00, 0, 5'd6, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd5, 7'h00, 0, 5'd7, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd5, 7'h20, 0, 5'd8, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd6, 7'h00, 0, 5'd9, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0110011, 3'd7, 7'h00, 0, 5'd10, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd0, 7'h00, 1, 5'd1, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd2, 7'h00, 1, 5'd4, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd3, 7'h00, 1, 5'd5, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd4, 7'h00, 1, 5'd6, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd6, 7'h00, 1, 5'd9, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd7, 7'h00, 1, 5'd10, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd1, 7'h00, 2, 5'd11, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd5, 7'h00, 2, 5'd12, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0010011, 3'd5, 7'h20, 2, 5'd13, 0, 1, 0, 0, 0, 1);
    add_ent(7'b0000011, 3'd0, 7'h00, 1, 5'd1, 0, 1, 1, 0, 1, 1);
    add_ent(7'b0000011, 3'd1, 7'h00, 1, 5'd1, 0, 1, 2, 0, 1, 1);
    add_ent(7'b0000011, 3'd2, 7'h00, 1, 5'd1, 0, 1, 3, 0, 1, 1);
    add_ent(7'b0000011, 3'd4, 7'h00, 1, 5'd1, 0, 1, 4, 0, 1, 1);
    add_ent(7'b0000011, 3'd5, 7'h00, 1, 5'd1, 0, 1, 5, 0, 1, 1);
    add_ent(7'b0100011, 3'd0, 7'h00, 3, 5'd1, 0, 1, 0, 1, 0, 0);
    add_ent(7'b0100011, 3'd1, 7'h00, 3, 5'd1, 0, 1, 0, 2, 0, 0);
    add_ent(7'b0100011, 3'd2, 7'h00, 3, 5'd1, 0, 1, 0, 3, 0, 0);
    add_ent(7'b1100011, 3'd0, 7'h00, 4, 5'd15, 0, 0, 0, 0, 0, 0);
    add_ent(7'b1100011, 3'd1, 7'h00, 4, 5'd16, 0, 0, 0, 0, 0, 0);
    add_ent(7'b1100011, 3'd4, 7'h00, 4, 5'd17, 0, 0, 0, 0, 0, 0);
    add_ent(7'b1100011, 3'd5, 7'h00, 4, 5'd18, 0, 0, 0, 0, 0, 0);
    add_ent(7'b1100011, 3'd6, 7'h00, 4, 5'd19, 0, 0, 0, 0, 0, 0);
    add_ent(7'b1100011, 3'd7, 7'h00, 4, 5'd20, 0, 0, 0, 0, 0, 0);
    add_ent(7'b0110111, 3'd0, 7'h00, 5, 5'd14, 0, 0, 0, 0, 0, 1);
    add_ent(7'b0010111, 3'd0, 7'h00, 5, 5'd1, 1, 1, 0, 0, 0, 1);
    add_ent(7'b1101111, 3'd0, 7'h00, 6, 5'd21, 1, 0, 0, 0, 0, 1);
    add_ent(7'b1100111, 3'd0, 7'h00, 1, 5'd22, 0, 0, 0, 0, 0, 1);
    #2 RST = 1'b1;
    #1;
    chk("reset_pc", PC_OUT, 32'd0);
    chk("reset_alu", 32'(ALU_INSTRUCTION), 32'd0);
    chk("reset_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    chk("reset_rs2d", RS2_DATA, 32'd0);
    @(negedge CLK) RST = 1'b0;
    step(32'h00200233, 32'd1, 0, 5'd0, 32'd0, 0, 0);
    chk("add_rs1a", 32'(RS1_ADDRESS), 32'd0);
    chk("add_rs2a", 32'(RS2_ADDRESS), 32'd2);
    chk("add_rda", 32'(RD_ADDRESS_OUT), 32'd4);
    chk("add_alu", 32'(ALU_INSTRUCTION), 32'd1);
    chk("add_sel", 32'({ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT}), 32'd0);
    chk("add_we", 32'(RD_WRITE_ENABLE_OUT), 32'd1);
    chk("add_pc", PC_OUT, 32'd1);
    chk("add_rs1d", RS1_DATA, 32'd0);
    chk("add_rs2d", RS2_DATA, 32'd0);
    step(32'h00200233, 32'd2, 1, 5'd2, 32'h12345678, 0, 0);
    chk("bypass_rs2d", RS2_DATA, 32'h12345678);
    step(32'h00200233, 32'd3, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
    chk("x0_rs1d", RS1_DATA, 32'd0);
    chk("stored_rs2d", RS2_DATA, 32'h12345678);
    step(32'hFFC0A283, 32'h10, 1, 5'd1, 32'h100, 0, 0);
    chk("lw_imm", IMM_OUTPUT, 32'hFFFFFFFC);
    chk("lw_alu", 32'(ALU_INSTRUCTION), 32'd1);
    chk("lw_sel2", 32'(ALU_INPUT_2_SELECT), 32'd1);
    chk("lw_read", 32'(DATA_CACHE_READ), 32'd3);
    chk("lw_wb", 32'(WRITE_BACK_MUX_SELECT), 32'd1);
    chk("lw_rs1d", RS1_DATA, 32'h100);
    step(32'h0050A423, 32'h14, 1, 5'd5, 32'hCAFEF00D, 0, 0);
    chk("sw_imm", IMM_OUTPUT, 32'd8);
    chk("sw_write", 32'(DATA_CACHE_WRITE), 32'd3);
    chk("sw_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    chk("sw_wdata", DATA_CACHE_WRITE_DATA, 32'hCAFEF00D);
    step(32'h4041D193, 32'h18, 0, 5'd0, 32'd0, 0, 0);
    chk("srai_alu", 32'(ALU_INSTRUCTION), 32'd13);
    chk("srai_shamt", 32'(SHIFT_AMOUNT), 32'd4);
    step(32'hFE000CE3, 32'h40, 0, 5'd0, 32'd0, 0, 0);
    chk("beq_alu", 32'(ALU_INSTRUCTION), 32'd15);
    chk("beq_imm", IMM_OUTPUT, 32'hFFFFFFF8);
    for (int i = 0; i < 2; i++) begin
      step(32'h00200233, 32'h99 + 32'(i), 0, 5'd0, 32'd0, 1, 0);
      chk("stall_alu", 32'(ALU_INSTRUCTION), 32'd15);
      chk("stall_imm", IMM_OUTPUT, 32'hFFFFFFF8);
      chk("stall_pc", PC_OUT, 32'h40);
    end
    step(32'h00200233, 32'h77, 0, 5'd0, 32'd0, 1, 1);
    chk("clear_alu", 32'(ALU_INSTRUCTION), 32'd0);
    chk("clear_pc", PC_OUT, 32'd0);
    chk("clear_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    step(32'h00200233, 32'd5, 0, 5'd0, 32'd0, 0, 0);
    chk("pre_rst_rs2d", RS2_DATA, 32'h12345678);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_pc", PC_OUT, 32'd0);
    chk("async_rst_alu", 32'(ALU_INSTRUCTION), 32'd0);
    chk("async_rst_rs2d", RS2_DATA, 32'd0);
    RST = 1'b0;
    step(32'h00200233, 32'd6, 0, 5'd0, 32'd0, 0, 0);
    chk("post_rst_rs2d", RS2_DATA, 32'd0);
    chk("post_rst_pc", PC_OUT, 32'd6);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    ex = '0;
    ex.pc = 32'd6;
    ex.rs2a = 5'd2;
    ex.rda = 5'd4;
    ex.sh = 5'd2;
    ex.alu = 5'd1;
    ex.we = 1'b1;
    ex_pc = 1'b1;
    for (int n = 0; n < 400; n++) begin
      RD_WRITE_ENABLE_IN = 1'($urandom_range(0, 1));
      RD_ADDRESS_IN = 5'($urandom);
      RD_DATA_IN = $urandom;
      PC_IN = $urandom;
      STALL_DECODING_STAGE = $urandom_range(0, 9) == 0;
      CLEAR_DECODING_STAGE = $urandom_range(0, 14) == 0;
      if ($urandom_range(0, 6) == 0) gen_illegal();
      else gen_valid(int'($urandom_range(0, tbl.size() - 1)));
      @(posedge CLK);
      if (CLEAR_DECODING_STAGE) begin
        ex = '0;
        ex_pc = 1'b1;
      end else if (!STALL_DECODING_STAGE) begin
        ex = nx;
        ex_pc = nx_pc;
      end
      if (RD_WRITE_ENABLE_IN && RD_ADDRESS_IN != 5'd0) mregs[RD_ADDRESS_IN] = RD_DATA_IN;
      #1;
      check_out();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rv32i_decoding_stage.md
# rv32i_decoding_stage

RV32I instruction-decode stage of the five-stage pipeline, between fetch and execute. It decodes the fetched instruction, reads operands from the 32×32 integer register file it contains, and absorbs write-back from the end of the pipeline. It registers all decoded fields and control into the ID/EX pipeline register, with stall and clear (bubble) control.

## Interface
- No parameters.
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- STALL_DECODING_STAGE  in  1  hold the ID/EX register.
- CLEAR_DECODING_STAGE  in  1  load a bubble into the ID/EX register.
- RD_ADDRESS_IN / RD_DATA_IN / RD_WRITE_ENABLE_IN  in  5/32/1  register-file write port from write-back.
- INSTRUCTION  in  32  instruction from fetch.
- PC_IN  in  32  PC of INSTRUCTION.
- PC_OUT  out  32  registered PC.
- RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_OUT  out  5 each  INSTRUCTION[19:15], [24:20], [11:7].
- RS1_DATA, RS2_DATA  out  32 each  register operands.
- IMM_OUTPUT  out  32  sign-extended immediate.
- SHIFT_AMOUNT  out  5  INSTRUCTION[24:20].
- ALU_INSTRUCTION  out  5  ALU operation code.
- ALU_INPUT_1_SELECT  out  1  0 = RS1_DATA, 1 = PC.
- ALU_INPUT_2_SELECT  out  1  0 = RS2_DATA, 1 = IMM_OUTPUT.
- DATA_CACHE_READ  out  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- DATA_CACHE_WRITE  out  2  0 none, 1 SB, 2 SH, 3 SW.
- DATA_CACHE_WRITE_DATA  out  32  store data (= RS2 operand).
- WRITE_BACK_MUX_SELECT  out  1  0 = ALU result, 1 = memory data.
- RD_WRITE_ENABLE_OUT  out  1  instruction writes rd.

## Operation
- ALU codes: 0 NOP, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND, 11 SLLI, 12 SRLI, 13 SRAI, 14 LUI, 15 BEQ, 16 BNE, 17 BLT, 18 BGE, 19 BLTU, 20 BGEU, 21 JAL, 22 JALR.
- OP (0110011): code from funct3/funct7; sel1=0, sel2=0, write enable=1, IMM=0.
- OP-IMM (0010011): I-imm; sel2=1; ADDI→ADD, SLTI→SLT, etc.; shifts use 11/12/13, with funct7[5] selecting SRAI.
- LOAD (0000011): ADD, sel2=1, I-imm; DATA_CACHE_READ from funct3; WB select=1; write enable=1.
- STORE (0100011): ADD, sel2=1, S-imm; DATA_CACHE_WRITE from funct3; write enable=0.
- BRANCH (1100011): codes 15–20, B-imm, sel1=0, sel2=0, write enable=0.
- LUI: code 14, U-imm, write enable=1.
- AUIPC: ADD, sel1=1, sel2=1, U-imm, write enable=1.
- JAL: code 21, J-imm, sel1=1, write enable=1.
- JALR: code 22, I-imm, write enable=1.
- Any other opcode or funct combination decodes as a bubble.
- Bubble: all control outputs 0 (ALU code 0, no cache access, write enable 0). Address/data/imm fields are don't-care but driven 0.
- Register file: x0 reads 0 and ignores writes. Write on the rising edge when RD_WRITE_ENABLE_IN=1 and RD_ADDRESS_IN≠0. Reads are combinational with write-through bypass: a same-cycle write to the read address returns RD_DATA_IN.

## Timing
- RST asserted: all outputs 0 and all 32 registers 0, immediately and asynchronously. Reset mid-operation discards the pipeline contents.
- Latency: one cycle; outputs reflect INSTRUCTION/PC_IN sampled at the previous rising edge.
- Priority at an edge: RST > CLEAR (bubble, PC_OUT=0) > STALL (hold all outputs) > normal load.
- Register-file writes proceed regardless of STALL and CLEAR.

## Test plan
- Reset, then INSTRUCTION=0x00200233 (add x4,x0,x2), PC_IN=1, one edge -> RS1_ADDRESS=0, RS2_ADDRESS=2, RD_ADDRESS_OUT=4, ALU=1, selects 0/0, RD_WRITE_ENABLE_OUT=1, PC_OUT=1, RS1/RS2_DATA=0.
- Write x2=0x12345678 at the same edge as decoding the add above -> RS2_DATA=0x12345678 (bypass). A write to x0 -> RS1_DATA stays 0.
- lw x5,-4(x1) (0xFFC0A283) -> IMM=0xFFFFFFFC, ALU=1, sel2=1, DATA_CACHE_READ=3, WB select=1. sw x5,8(x1) (0x0050A423) -> IMM=8, DATA_CACHE_WRITE=3, write enable=0.
- srai x3,x3,4 (0x4041D193) -> ALU=13, SHIFT_AMOUNT=4. beq with offset -8 (0xFE000CE3) -> ALU=15, IMM=0xFFFFFFF8.
- STALL held over 2 edges while INSTRUCTION changes -> outputs unchanged. CLEAR and STALL together -> bubble.
- RST pulse between edges -> outputs 0 immediately; registers previously written read back 0.
